// File: rtl/kbd_fifo.sv
// Keyboard receive buffer: circular byte FIFO between the PS/2 decoder and the CPU data/status ports.
// Latency: zero cycles, first-word fall-through; a byte pushed at edge N is on dout right after edge N.
// Backpressure: none to the decoder; a key arriving while full (no coincident read) is dropped and sets sticky overflow.
module kbd_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  kb_done,
    input  logic [7:0]            kb_data,
    input  logic                  rd,
    input  logic                  clr,
    output logic [7:0]            dout,
    output logic                  ready,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  irq,
    output logic [7:0]            status
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   cnt_q;
    logic                  ovf_q;
    logic                  irq_q;

    logic                  is_empty;
    logic                  is_full;
    logic                  push_ok;
    logic                  pop_ok;
    logic                  drop;

    // Accept/drop decisions; a read in the same cycle frees the slot a full-buffer push needs.
    always_comb begin
        is_empty = (cnt_q == '0);
        is_full  = (cnt_q == DEPTH_CNT);
        push_ok  = kb_done && !clr && (!is_full || rd);
        pop_ok   = rd && !clr && !is_empty;
        drop     = kb_done && !clr && is_full && !rd;
    end

    // Pointers, occupancy, sticky overflow and the empty-to-non-empty interrupt pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push_ok && !pop_ok) begin
                cnt_q <= cnt_q + CNT_ONE;
            end else if (pop_ok && !push_ok) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            // A push into an empty buffer can never coincide with an accepted pop.
            irq_q <= is_empty && push_ok;
        end
    end

    // Byte storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= kb_data;
        end
    end

    // CPU-visible outputs, all derived from registered state.
    always_comb begin
        dout     = is_empty ? 8'h00 : mem[rd_ptr];
        ready    = !is_empty;
        full     = is_full;
        count    = cnt_q;
        overflow = ovf_q;
        irq      = irq_q;
        status   = {ovf_q, is_full, !is_empty, 5'b0};
    end

endmodule

// File: doc/kbd_fifo.md
KBD_FIFO -- requirements
Module: kbd_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, log2 of buffer depth (16 entries).
REQ-002 clock  input  1  system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 kb_done  input  1  one-clock strobe from the PS/2 decoder: kb_data holds a valid ASCII/control code.
REQ-005 kb_data  input  8  key code, sampled only when kb_done=1.
REQ-006 rd  input  1  CPU read strobe of the data port; pops the head entry.
REQ-007 clr  input  1  synchronous flush: empties the buffer and clears overflow.
REQ-008 dout  output  8  head entry (first-word fall-through); 8'h00 when empty.
REQ-009 ready  output  1  buffer non-empty.
REQ-010 full  output  1  count equals 2^DEPTH_LOG2.
REQ-011 count  output  DEPTH_LOG2+1  number of stored entries, 0..2^DEPTH_LOG2.
REQ-012 overflow  output  1  sticky: a key was dropped because the buffer was full.
REQ-013 irq  output  1  registered one-clock pulse on the empty-to-non-empty transition.
REQ-014 status  output  8  {overflow, full, ready, 5'b0} for the CPU status port.

Function
REQ-015 Storage: circular buffer of 2^DEPTH_LOG2 bytes; write and read pointers DEPTH_LOG2 bits wide, wrapping modulo depth with no special case at the top address.
REQ-016 Push: on a rising edge with kb_done=1, clr=0 and count<depth, store kb_data at the write pointer, advance the write pointer, and increment count.
REQ-017 Pop: on a rising edge with rd=1, clr=0 and count>0, advance the read pointer and decrement count.
REQ-018 Pop on empty: rd with count=0 is ignored; pointers, count and dout are unchanged, and the overflow flag is not affected.
REQ-019 Simultaneous push and pop with 0<count<depth: both are performed and count is unchanged.
REQ-020 Push when full: if rd=1 in the same cycle, the push is accepted and count stays at depth.
REQ-021 Push when full without rd: kb_data is dropped, overflow is set to 1, and all stored entries are unchanged.
REQ-022 Simultaneous push and pop with count=0: the push is accepted, the pop is ignored, and count becomes 1.
REQ-023 clr has priority: in a clr cycle, both pointers go to 0, count goes to 0, and overflow goes to 0; a coincident push or pop is discarded.
REQ-024 overflow is cleared only by clr or by reset.
REQ-025 Latency: a byte pushed at edge N appears on dout, with ready=1, immediately after edge N (zero extra cycles).
REQ-026 dout is combinational from the storage at the read pointer, gated to 8'h00 while count=0.
REQ-027 irq is 1 for exactly the one cycle following the edge where count goes from 0 to nonzero; it is 0 otherwise, including in clr cycles.
REQ-028 full, ready and status are derived combinationally from count and overflow.
REQ-029 kb_data is ignored whenever kb_done=0; no edge detection is applied to kb_done (the input is already a single-clock pulse).

Reset
REQ-030 When reset_n=0, asynchronously: both pointers=0, count=0, overflow=0, irq=0. As a result dout=8'h00, ready=0, full=0 and status=8'h00. Storage contents are don't-care.
REQ-031 Reset asserted mid-operation discards all buffered entries; the first push after reset_n rises lands at storage address 0.
REQ-032 Reset deassertion is consumed synchronously by the surrounding design; the block has no further reset sequencing.

Verification
REQ-033 Push 8'h61 then 8'h62, then rd twice -> dout reads 61 then 62; count goes 1,2,1,0; irq pulses once, after the first push; ready=0 at the end.
REQ-034 Push 17 bytes 8'h30..8'h40 with no reads -> count=16, full=1, overflow=1, status=8'hE0; the 16 reads return 30..3F; 8'h40 is lost.
REQ-035 With count=16, push 8'h41 and rd in the same cycle -> count stays 16, overflow stays 0, and 8'h41 is the last byte read out.
REQ-036 With count=0, push 8'h0A and rd in the same cycle -> count=1, dout=8'h0A, irq pulses.
REQ-037 Fill to 5 entries with overflow set, then clr together with kb_done -> count=0, overflow=0, dout=8'h00, no irq; the next push of 8'h1B is read back as 8'h1B.
REQ-038 Run 40 push/pop pairs so the pointers wrap twice -> read order matches write order with no loss.
REQ-039 Assert reset_n=0 while count=3 -> outputs reach their reset values without waiting for a clock edge.
